// File: rtl/shift_add_mul_if.sv
// Request/result bundle for the shift-and-add multiplier.
// master drives start/a/b; slave (the multiplier) returns status and product.
interface shift_add_mul_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (output start, a, b, input ready, busy, done, p);
  modport slave  (input start, a, b, output ready, busy, done, p);
endinterface

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier, one W-bit ripple add per clock.
// Optional macro MUL_ZERO_SKIP_EN: zero operands bypass CALC and complete immediately.
module shift_add_mul #(
  parameter int W = 4
) (
  input logic             clk,
  input logic             rst,
  shift_add_mul_if.slave  bus
);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_h;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_p;

  logic [W-1:0]   w_addend;
  logic [W-1:0]   w_s;
  logic [W:0]     w_c;
  logic [2*W-1:0] w_next;

  // Operand mux: addend is A when the current multiplier bit is set.
  assign w_addend = r_q[0] ? r_a : '0;

  assign w_c[0] = 1'b0;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign w_s[i]   = r_h[i] ^ w_addend[i] ^ w_c[i];
    assign w_c[i+1] = (r_h[i] & w_addend[i]) | (w_c[i] & (r_h[i] ^ w_addend[i]));
  end

  // Carry-out is shifted straight into H, so no separate carry register is kept.
  assign w_next = {w_c[W], w_s, r_q[W-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_h     <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a;
            r_q   <= bus.b;
            r_h   <= '0;
            r_cnt <= '0;
`ifdef MUL_ZERO_SKIP_EN
            if (bus.a == '0 || bus.b == '0) begin
              r_p     <= '0;
              r_state <= DONE;
            end else begin
              r_state <= CALC;
            end
`else
            r_state <= CALC;
`endif
          end
        end
        CALC: begin
          r_h   <= w_next[2*W-1:W];
          r_q   <= w_next[W-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_p     <= w_next;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (r_state == IDLE);
  assign bus.busy  = (r_state == CALC);
  assign bus.done  = (r_state == DONE);
  assign bus.p     = r_p;
endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul at W=4: products, latency, p hold, reset abort.
module tb_shift_add_mul;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_add_mul_if #(.W(W)) bus ();
  shift_add_mul #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;
  int unsigned cyc    = 0;
  int unsigned n_done = 0;
  int unsigned n_exp  = 0;
  logic [2*W-1:0] last_p = '0;
  logic [2*W-1:0] exp_q[$];
  int unsigned    lat_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples 1 time unit after the falling edge, after the driver settles.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check_eq("onehot", 32'($countones({bus.ready, bus.busy, bus.done})), 32'd1);
      if (bus.start && bus.ready) begin
`ifdef MUL_ZERO_SKIP_EN
        if (bus.a == '0 || bus.b == '0) lat_q.push_back(cyc + 1);
        else                            lat_q.push_back(cyc + 1 + W);
`else
        lat_q.push_back(cyc + 1 + W);
`endif
      end
      if (bus.done) begin
        n_done++;
        if (exp_q.size() > 0) begin
          last_p = exp_q.pop_front();
          check_eq("product", 32'(bus.p), 32'(last_p));
        end
        if (lat_q.size() > 0) check_eq("done_cycle", cyc, lat_q.pop_front());
      end else begin
        check_eq("p_hold", 32'(bus.p), 32'(last_p));
      end
    end
  end

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) check_eq("ready_timeout", 32'd0, 32'd1);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back((2*W)'(a) * (2*W)'(b));
    n_exp++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom_range(0, 15);
    bus.b     = $urandom_range(0, 15);
  endtask

  task automatic wait_idle();
    int unsigned guard = 0;
    while (!(bus.ready && exp_q.size() == 0) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_eq("idle_reached", {31'd0, bus.ready && exp_q.size() == 0}, 32'd1);
  endtask

  // Caller is at a falling edge; rst is sampled on the following rising edge(s).
  task automatic apply_reset(input int unsigned cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    n_exp  = n_exp - exp_q.size();
    exp_q.delete();
    lat_q.delete();
    last_p = '0;
    rst    = 1'b0;
    #1;
    check_eq("rst_ready", {31'd0, bus.ready}, 32'd1);
    check_eq("rst_busy",  {31'd0, bus.busy},  32'd0);
    check_eq("rst_done",  {31'd0, bus.done},  32'd0);
    check_eq("rst_p",     32'(bus.p),         32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    @(negedge clk);
    apply_reset(2);

    do_start(4'd13, 4'd11);
    wait_idle();
    check_eq("p_13x11", 32'(bus.p), 32'h8F);

    do_start(4'd15, 4'd15);
    do_start(4'd1, 4'd8);
    check_eq("p_held_e1", 32'(bus.p), 32'hE1);
    wait_idle();
    check_eq("p_1x8", 32'(bus.p), 32'h08);

    do_start(4'd6, 4'd5);
    bus.start = 1'b1;
    bus.a     = 4'd2;
    bus.b     = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    check_eq("p_6x5", 32'(bus.p), 32'h1E);

    do_start(4'd9, 4'd7);
    @(negedge clk);
    apply_reset(1);
    repeat (8) @(negedge clk);
    check_eq("abort_p", 32'(bus.p), 32'h00);

    do_start(4'd3, 4'd3);
    wait_idle();
    check_eq("p_3x3", 32'(bus.p), 32'h09);

    do_start(4'd0, 4'd12);
    wait_idle();
    do_start(4'd5, 4'd0);
    wait_idle();
    do_start(4'd1, 4'd1);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      do_start(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    wait_idle();

    check_eq("done_count", n_done, n_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/shift_add_mul.md
Name: shift_add_mul

Overview:
- Sequential unsigned shift-and-add multiplier; one W-bit partial-product add per clock.
- Drives the team's W-bit ripple-carry adder (fa chain) and the W-bit 2-to-1 operand mux (mx2b4 at W=4), and consumes their outputs.
- Sits directly upstream of the ripple adder; used as the first multi-cycle FSM exercising adder propagation delay.

Parameters:
- W, 4, operand width in bits; product is 2W bits; W >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  W  multiplicand, unsigned
- b  input  W  multiplier, unsigned
- ready  output  1  high only in IDLE
- busy  output  1  high in CALC
- done  output  1  one-cycle pulse, high in DONE
- p  output  2W  product; holds last result until next completion

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE, ready=1, busy=0, done=0, p=0, internal A, Q, H, C, cnt all 0. Reset mid-operation aborts the operation with no done pulse.
- Registers:
  - A (W): latched multiplicand.
  - Q (W): multiplier / product low half.
  - H (W): accumulator high half.
  - C (1): adder carry.
  - cnt: step counter, ceil(log2(W+1)) bits.
- State IDLE:
  - start=1 -> A<=a, Q<=b, H<=0, C<=0, cnt<=0; next state CALC.
  - start=0 -> stay in IDLE.
- State CALC, each edge:
  - addend = Q[0] ? A : 0, selected through the W-bit 2-to-1 mux.
  - {C', S} = H + addend, a W-bit ripple add with cin=0 and carry out C'.
  - {H, Q} <= {C', S, Q[W-1:1]}, i.e. a right shift of {C', S, Q} by one.
  - cnt <= cnt+1.
  - When cnt==W-1 on this edge: p <= {C', S, Q[W-1:1]}; next state DONE.
- State DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency:
  - start sampled at edge 0.
  - CALC steps at edges 1..W.
  - done high between edges W and W+1; ready high again after edge W+1.
  - Throughput is one product per W+2 clocks.
- start while ready=0 (CALC or DONE) is ignored; a, b are don't-care outside the IDLE start edge.
- No overflow is possible: a full 2W-bit product is always produced; max (2^W-1)^2 fits.
- p changes only on the completing CALC edge or on reset.
- ready, busy and done are decoded from state only; exactly one is high at any time.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: in IDLE, if start=1 and (a==0 or b==0), the block skips CALC.
  - p<=0 and state goes to DONE on edge 0; done is high between edges 0 and 1.
  - Non-zero operands keep the normal W-step latency.
- Undefined: zero operands take the full W steps; p=0 at the normal done time.

Test Plan:
- W=4, rst held 2 cycles -> ready=1, busy=0, done=0, p=0x00.
- a=13, b=11, start pulse at edge 0 -> busy during edges 1..4; done single pulse after edge 4; p=0x8F (143); ready after edge 5.
- a=15, b=15 then immediately a=1, b=8 back-to-back (start re-asserted on the first ready cycle) -> p=0xE1 (225), then p=0x08; p holds 0xE1 until the second completion.
- a=6, b=5 started, then start pulsed with a=2, b=2 during CALC -> ignored; p=0x1E (30); exactly one done pulse.
- a=9, b=7 started, rst=1 at edge 2 -> IDLE, p=0x00, no done pulse; a subsequent a=3, b=3 gives p=0x09.
- a=0, b=12 -> without MUL_ZERO_SKIP_EN: done after edge 4, p=0x00. With MUL_ZERO_SKIP_EN: done after edge 0, p=0x00, and busy never asserted.
